// File: rtl/obstacle_sequencer.sv
// obstacle_sequencer
// Game-side controller for the obstacle generators' start/done handshake.
// Picks the next obstacle, strobes done_control with a one-hot selected,
// waits for the generator to finish, and meanwhile runs a two-stage
// collision check of the reported obstacle pixels against the player box,
// tracking hit points down to game over.
//
// Build option: define SEQ_RANDOM_ORDER_EN to pick the next obstacle from an
// 8-bit LFSR (never repeating back-to-back) instead of the fixed 0,1,2,3 order.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for play_selected with the menu closed
// GAP   | idle pause of GAP_CYCLES between obstacles
// START | one-cycle done_control strobe with selected driven
// RUN   | obstacle running; selected held until done or watchdog
// OVER  | hit points exhausted; game_over held until play drops or menu opens

module obstacle_sequencer #(
    parameter int GAP_CYCLES   = 6_500_000,
    parameter int HIT_COOLDOWN = 65_000_000,
    parameter int PLAYER_SIZE  = 32,
    parameter int HP_INIT      = 3
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        play_selected,
    input  logic        menu_on,
    input  logic [11:0] obstacle_x,
    input  logic [11:0] obstacle_y,
    input  logic        obstacle_done,
    input  logic        obstacle_working,
    input  logic [11:0] player_xpos,
    input  logic [11:0] player_ypos,
    output logic [3:0]  selected,
    output logic        done_control,
    output logic [3:0]  hp,
    output logic        hit,
    output logic        game_over,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GAP   = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // GAP counts down from GAP_CYCLES-1 to 0, so GAP lasts exactly GAP_CYCLES cycles.
    localparam logic [26:0] GAP_LOAD  = 27'(GAP_CYCLES - 1);
    localparam logic [26:0] COOL_LOAD = 27'(HIT_COOLDOWN);
    localparam logic [12:0] BOX_SPAN  = 13'(PLAYER_SIZE - 1);
    localparam logic [3:0]  HP_LOAD   = 4'(HP_INIT);

    state_t      state;
    state_t      state_nxt;
    logic [26:0] gap_cnt;
    logic [26:0] cool_cnt;
    logic [2:0]  wd_cnt;
    logic [1:0]  idx;
    logic [1:0]  idx_adv;
    logic [3:0]  hp_q;
    logic        hit_q;
    logic [11:0] stg_x;
    logic [11:0] stg_y;

    logic        abort;
    logic        active;
    logic        in_box;
    logic        take_hit;
    logic        last_hp;
    logic        run_end;
    logic [12:0] x_hi;
    logic [12:0] y_hi;

    assign abort  = menu_on || !play_selected;
    assign active = (state == ST_GAP) || (state == ST_START) || (state == ST_RUN);

    // Box edges computed in 13 bits so a player near the right/bottom edge does not wrap.
    assign x_hi   = {1'b0, player_xpos} + BOX_SPAN;
    assign y_hi   = {1'b0, player_ypos} + BOX_SPAN;
    assign in_box = ((stg_x != 12'd0) || (stg_y != 12'd0)) &&
                    (stg_x >= player_xpos) && ({1'b0, stg_x} <= x_hi) &&
                    (stg_y >= player_ypos) && ({1'b0, stg_y} <= y_hi);

    // Abort beats a simultaneous hit: no decrement, no cooldown load.
    assign take_hit = active && !abort && in_box && (cool_cnt == 27'd0);
    assign last_hp  = take_hit && (hp_q == 4'd1);

    // The watchdog fires on the fourth consecutive cycle with working low.
    assign run_end  = (state == ST_RUN) &&
                      (obstacle_done || (!obstacle_working && (wd_cnt == 3'd3)));

`ifdef SEQ_RANDOM_ORDER_EN
    logic [7:0] lfsr;

    // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign idx_adv = (lfsr[1:0] == idx) ? (idx + 2'd1) : lfsr[1:0];
`else
    assign idx_adv = idx + 2'd1;
`endif

    // State register.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and decoded outputs; abort first, then hp exhaustion, then normal flow.
    always_comb begin
        state_nxt    = state;
        done_control = 1'b0;
        selected     = 4'd0;
        busy         = 1'b0;
        game_over    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (play_selected && !menu_on) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (last_hp) begin
                    state_nxt = ST_OVER;
                end else if (gap_cnt == 27'd0) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                busy         = 1'b1;
                done_control = 1'b1;
                selected     = 4'b0001 << idx;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (last_hp) begin
                    state_nxt = ST_OVER;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                selected = 4'b0001 << idx;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (last_hp) begin
                    state_nxt = ST_OVER;
                end else if (run_end) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_OVER: begin
                game_over = 1'b1;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Gap timer, watchdog, obstacle index and pixel pipeline stage 1.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
            wd_cnt  <= '0;
            idx     <= '0;
            stg_x   <= '0;
            stg_y   <= '0;
        end else begin
            stg_x <= obstacle_x;
            stg_y <= obstacle_y;

            if ((state != ST_GAP) && (state_nxt == ST_GAP)) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == ST_GAP) && (state_nxt == ST_GAP)) begin
                gap_cnt <= gap_cnt - 27'd1;
            end else begin
                gap_cnt <= '0;
            end

            if ((state == ST_RUN) && (state_nxt == ST_RUN) && !obstacle_working) begin
                wd_cnt <= wd_cnt + 3'd1;
            end else begin
                wd_cnt <= '0;
            end

            if (state == ST_IDLE || state_nxt == ST_IDLE) begin
                idx <= 2'd0;
            end else if (run_end && (state_nxt == ST_GAP)) begin
                idx <= idx_adv;
            end
        end
    end

    // Hit points, cooldown and the registered hit pulse (collision stage 2).
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hp_q     <= '0;
            hit_q    <= 1'b0;
            cool_cnt <= '0;
        end else begin
            hit_q <= take_hit;

            if ((state == ST_IDLE) && (state_nxt == ST_GAP)) begin
                hp_q <= HP_LOAD;
            end else if (take_hit && (hp_q != 4'd0)) begin
                hp_q <= hp_q - 4'd1;
            end

            if (take_hit) begin
                cool_cnt <= COOL_LOAD;
            end else if (state_nxt == ST_IDLE) begin
                cool_cnt <= '0;
            end else if (cool_cnt != 27'd0) begin
                cool_cnt <= cool_cnt - 27'd1;
            end
        end
    end

    assign hp  = hp_q;
    assign hit = hit_q;

endmodule

// File: tb/tb_obstacle_sequencer.sv
// tb_obstacle_sequencer
// Directed and randomized stimulus for obstacle_sequencer, checked every cycle
// against a behavioural model built from elapsed-cycle counts and hit
// timestamps. Honours SEQ_RANDOM_ORDER_EN when defined.

module tb_obstacle_sequencer;

    localparam int GAP  = 10;
    localparam int COOL = 20;
    localparam int PS   = 16;
    localparam int HPI  = 3;

    localparam int P_IDLE  = 0;
    localparam int P_GAP   = 1;
    localparam int P_START = 2;
    localparam int P_RUN   = 3;
    localparam int P_OVER  = 4;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        play_selected = 1'b0;
    logic        menu_on = 1'b0;
    logic [11:0] obstacle_x = '0;
    logic [11:0] obstacle_y = '0;
    logic        obstacle_done = 1'b0;
    logic        obstacle_working = 1'b0;
    logic [11:0] player_xpos = 12'd100;
    logic [11:0] player_ypos = 12'd200;
    logic [3:0]  selected;
    logic        done_control;
    logic [3:0]  hp;
    logic        hit;
    logic        game_over;
    logic        busy;

    obstacle_sequencer #(
        .GAP_CYCLES  (GAP),
        .HIT_COOLDOWN(COOL),
        .PLAYER_SIZE (PS),
        .HP_INIT     (HPI)
    ) dut (
        .pclk            (pclk),
        .rst_n           (rst_n),
        .play_selected   (play_selected),
        .menu_on         (menu_on),
        .obstacle_x      (obstacle_x),
        .obstacle_y      (obstacle_y),
        .obstacle_done   (obstacle_done),
        .obstacle_working(obstacle_working),
        .player_xpos     (player_xpos),
        .player_ypos     (player_ypos),
        .selected        (selected),
        .done_control    (done_control),
        .hp              (hp),
        .hit             (hit),
        .game_over       (game_over),
        .busy            (busy)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model
    int m_phase, m_elapsed, m_low, m_idx, m_hp, m_hit;
    int m_edge, m_last, m_sx, m_sy, m_lfsr;
    int last_sel = -1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_elapsed = 0; m_low = 0; m_idx = 0; m_hp = 0; m_hit = 0;
        m_edge = 0; m_last = -1000; m_sx = 0; m_sy = 0; m_lfsr = 8'hA5;
    endtask

    task automatic model_edge();
        int  px, py, nidx, fb;
        bit  abort, act, inbox, hitc, last_hp, advance;
        px      = int'(player_xpos);
        py      = int'(player_ypos);
        abort   = menu_on || !play_selected;
        act     = (m_phase == P_GAP) || (m_phase == P_START) || (m_phase == P_RUN);
        inbox   = ((m_sx != 0) || (m_sy != 0)) &&
                  (m_sx >= px) && (m_sx <= px + PS - 1) &&
                  (m_sy >= py) && (m_sy <= py + PS - 1);
        hitc    = act && !abort && inbox && (m_edge - m_last > COOL);
        last_hp = hitc && (m_hp == 1);
        advance = 1'b0;
`ifdef SEQ_RANDOM_ORDER_EN
        nidx = ((m_lfsr & 3) == m_idx) ? (m_idx + 1) % 4 : (m_lfsr & 3);
`else
        nidx = (m_idx + 1) % 4;
`endif
        if (m_phase == P_IDLE) begin
            if (play_selected && !menu_on) begin
                m_phase = P_GAP; m_elapsed = 0; m_idx = 0; m_hp = HPI; m_last = -1000;
            end
        end else if (m_phase == P_OVER) begin
            if (abort) m_phase = P_IDLE;
        end else if (abort) begin
            m_phase = P_IDLE;
        end else if (last_hp) begin
            m_phase = P_OVER;
        end else if (m_phase == P_GAP) begin
            m_elapsed++;
            if (m_elapsed == GAP) m_phase = P_START;
        end else if (m_phase == P_START) begin
            m_phase = P_RUN; m_low = 0;
        end else begin
            if (obstacle_done) advance = 1'b1;
            else if (!obstacle_working) begin
                m_low++;
                if (m_low == 4) advance = 1'b1;
            end else m_low = 0;
            if (advance) begin
                m_idx = nidx; m_phase = P_GAP; m_elapsed = 0;
            end
        end
        if (hitc) begin
            if (m_hp > 0) m_hp--;
            m_last = m_edge;
        end
        m_hit  = hitc;
        fb     = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 255;
        m_sx   = int'(obstacle_x);
        m_sy   = int'(obstacle_y);
        m_edge++;
    endtask

    task automatic compare_outputs(input string pfx);
        int exp_sel;
        exp_sel = ((m_phase == P_START) || (m_phase == P_RUN)) ? (1 << m_idx) : 0;
        chk({pfx, ".selected"},     int'(selected),     exp_sel);
        chk({pfx, ".done_control"}, int'(done_control), int'(m_phase == P_START));
        chk({pfx, ".hp"},           int'(hp),           m_hp);
        chk({pfx, ".hit"},          int'(hit),          m_hit);
        chk({pfx, ".game_over"},    int'(game_over),    int'(m_phase == P_OVER));
        chk({pfx, ".busy"},         int'(busy),
            int'((m_phase == P_GAP) || (m_phase == P_START) || (m_phase == P_RUN)));
`ifdef SEQ_RANDOM_ORDER_EN
        if (done_control) begin
            chk({pfx, ".repeat"}, int'(int'(selected) == last_sel), 0);
            last_sel = int'(selected);
        end
`endif
    endtask

    task automatic tick(input string pfx);
        @(posedge pclk);
        model_edge();
        #1;
        compare_outputs(pfx);
    endtask

    task automatic wait_phase(input int target, input int budget, input string pfx);
        int n;
        n = 0;
        while (m_phase != target && n < budget) begin
            tick(pfx);
            n++;
        end
        if (m_phase != target) chk({pfx, ".wait_timeout"}, m_phase, target);
    endtask

    task automatic set_xy(input int x, input int y);
        obstacle_x = 12'(x);
        obstacle_y = 12'(y);
    endtask

    initial begin
        int n, v, px, dead;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        compare_outputs("reset");
        rst_n = 1'b1;

        // sequencing and start latency
        play_selected    = 1'b1;
        obstacle_working = 1'b1;
        n = 0;
        while (!done_control && n < 40) begin
            tick("seq");
            n++;
        end
        chk("start_latency", n, GAP + 1);
        for (int k = 0; k < 5; k++) begin
            wait_phase(P_RUN, 40, "seq");
            tick("seq");
            obstacle_done = 1'b1;
            tick("seq");
            obstacle_done = 1'b0;
        end

        // collision latency and boundaries
        set_xy(115, 215);
        tick("col");
        set_xy(0, 0);
        tick("col");
        chk("hit_latency", int'(hit), 1);
        chk("hp_after_hit", int'(hp), 2);
        repeat (25) tick("col");
        set_xy(116, 215);
        tick("col");
        set_xy(0, 0);
        repeat (3) tick("col");
        player_xpos = 12'd0;
        player_ypos = 12'd0;
        repeat (3) tick("col");
        player_xpos = 12'd100;
        player_ypos = 12'd200;

        // cooldown and game over
        for (int i = 0; i < 25; i++) begin
            if (i == 0 || i == 5 || i == 21) set_xy(110, 210);
            else set_xy(0, 0);
            tick("cool");
        end
        chk("hp_zero", int'(hp), 0);
        chk("game_over_set", int'(game_over), 1);
        chk("selected_over", int'(selected), 0);
        play_selected = 1'b0;
        tick("over");
        chk("game_over_clr", int'(game_over), 0);
        play_selected = 1'b1;

        // menu abort during RUN, then watchdog
        wait_phase(P_RUN, 40, "abort");
        menu_on = 1'b1;
        tick("abort");
        chk("abort_busy", int'(busy), 0);
        chk("abort_sel", int'(selected), 0);
        menu_on          = 1'b0;
        obstacle_working = 1'b0;
        wait_phase(P_START, 40, "wd");
        repeat (5) tick("wd");
        chk("wd_busy", int'(busy), 1);
        chk("wd_sel", int'(selected), 0);
        obstacle_working = 1'b1;

        // asynchronous reset in RUN
        wait_phase(P_RUN, 40, "arst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        last_sel = -1;
        compare_outputs("arst");
        @(posedge pclk);
        #1;
        compare_outputs("arst_hold");
        rst_n = 1'b1;

        // randomized play
        dead = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 250) begin
                player_xpos = ($urandom % 4 == 0) ? 12'(4090 + $urandom % 6) : 12'($urandom % 4096);
                player_ypos = ($urandom % 4 == 0) ? 12'(4090 + $urandom % 6) : 12'($urandom % 4096);
            end
            if (m_phase == P_OVER)      play_selected = ($urandom % 8 != 0);
            else if (m_phase == P_IDLE) play_selected = ($urandom % 2 == 0);
            else                        play_selected = ($urandom % 300 != 0);
            menu_on = ($urandom % 200 == 0);
            if (m_phase == P_START) dead = ($urandom % 5 == 0);
            obstacle_working = dead ? 1'b0 : ($urandom % 8 != 0);
            obstacle_done    = (m_phase == P_RUN) && ($urandom % 10 == 0);
            case ($urandom % 4)
                1: begin
                    px = int'(player_xpos) - 2 + int'($urandom_range(0, PS + 3));
                    v  = int'(player_ypos) - 2 + int'($urandom_range(0, PS + 3));
                    if (px < 0) px = 0;
                    if (px > 4095) px = 4095;
                    if (v < 0) v = 0;
                    if (v > 4095) v = 4095;
                    set_xy(px, v);
                end
                2: set_xy(int'($urandom % 4096), int'($urandom % 4096));
                default: set_xy(0, 0);
            endcase
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
